// File: rtl/acc_mmu_arbiter_pkg.sv
// Shared widths and the exception record exchanged with the accelerator MMU port.
package acc_mmu_arbiter_pkg;

    localparam int unsigned VLEN = 64;
    localparam int unsigned PLEN = 56;
    localparam int unsigned PPNW = 44;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

endpackage

// File: rtl/acc_mmu_arbiter_lzc.sv
// Trailing-zero counter: index of the lowest set bit, purely combinational.
// No handshake; empty flags an all-zero input (count is then 0).
module acc_mmu_arbiter_lzc #(
    parameter int unsigned Width = 2,
    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] data,
    output logic [CntW-1:0]  cnt,
    output logic             empty
);

    always_comb begin
        cnt = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (data[i]) begin
                cnt = CntW'(i);
            end
        end
    end

    assign empty = ~|data;

endmodule

// File: rtl/acc_mmu_arbiter.sv
// Round-robin share of one accelerator MMU port; zero added latency both ways.
// Grant is locked until the MMU answers; flush/abandon drains a stale response first.
module acc_mmu_arbiter
    import acc_mmu_arbiter_pkg::*;
#(
    parameter int unsigned NrPorts     = 2,
    parameter int unsigned DrainCycles = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic [NrPorts-1:0]             req_i,
    input  logic [NrPorts-1:0][VLEN-1:0]   vaddr_i,
    input  logic [NrPorts-1:0]             is_store_i,
    input  exception_t [NrPorts-1:0]       misaligned_ex_i,
    output logic [NrPorts-1:0]             dtlb_hit_o,
    output logic [PPNW-1:0]                dtlb_ppn_o,
    output logic [NrPorts-1:0]             valid_o,
    output logic [PLEN-1:0]                paddr_o,
    output exception_t                     exception_o,
    output logic                           acc_mmu_req_o,
    output logic [VLEN-1:0]                acc_mmu_vaddr_o,
    output logic                           acc_mmu_is_store_o,
    output exception_t                     acc_mmu_misaligned_ex_o,
    input  logic                           acc_mmu_dtlb_hit_i,
    input  logic [PPNW-1:0]                acc_mmu_dtlb_ppn_i,
    input  logic                           acc_mmu_valid_i,
    input  logic [PLEN-1:0]                acc_mmu_paddr_i,
    input  exception_t                     acc_mmu_exception_i
);

    localparam int unsigned IdxW = $clog2(NrPorts);
    localparam int unsigned CntW = $clog2(DrainCycles + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [IdxW-1:0]     rr_q, rr_d;
    logic [CntW-1:0]     drain_cnt_q, drain_cnt_d;

    logic [NrPorts-1:0]  req_rot;
    logic [IdxW:0]       rot_idx;
    logic [IdxW:0]       grant_sum;
    logic [IdxW-1:0]     lzc_cnt;
    logic [IdxW-1:0]     grant;
    logic [IdxW-1:0]     sel;
    logic [IdxW-1:0]     owner_inc;
    logic                no_req;
    logic                mmu_req;
    logic [NrPorts-1:0]  hit_vec;
    logic [NrPorts-1:0]  valid_vec;

    // Rotate so that bit 0 of req_rot is port rr_q; lowest set bit is then the winner.
    always_comb begin
        rot_idx = '0;
        req_rot = '0;
        for (int i = 0; i < NrPorts; i++) begin
            rot_idx = {1'b0, rr_q} + (IdxW+1)'(i);
            if (rot_idx >= (IdxW+1)'(NrPorts)) begin
                rot_idx = rot_idx - (IdxW+1)'(NrPorts);
            end
            req_rot[i] = req_i[rot_idx[IdxW-1:0]];
        end
    end

    acc_mmu_arbiter_lzc #(
        .Width (NrPorts)
    ) u_lzc (
        .data  (req_rot),
        .cnt   (lzc_cnt),
        .empty (no_req)
    );

    always_comb begin
        grant_sum = {1'b0, rr_q} + {1'b0, lzc_cnt};
        if (grant_sum >= (IdxW+1)'(NrPorts)) begin
            grant_sum = grant_sum - (IdxW+1)'(NrPorts);
        end
        grant = grant_sum[IdxW-1:0];
    end

    assign owner_inc = (owner_q == IdxW'(NrPorts - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        drain_cnt_d = drain_cnt_q;
        sel         = owner_q;
        mmu_req     = 1'b0;
        hit_vec     = '0;
        valid_vec   = '0;
        case (state_q)
            IDLE: begin
                sel     = no_req ? '0 : grant;
                mmu_req = ~no_req;
                if (!no_req) begin
                    hit_vec[grant] = acc_mmu_dtlb_hit_i;
                    owner_d        = grant;
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                mmu_req          = req_i[owner_q];
                hit_vec[owner_q] = acc_mmu_dtlb_hit_i;
                // A response in the same cycle as a flush is still delivered.
                if (acc_mmu_valid_i) begin
                    valid_vec[owner_q] = 1'b1;
                    rr_d               = owner_inc;
                    state_d            = IDLE;
                end else if (flush_i || !req_i[owner_q]) begin
                    rr_d        = owner_inc;
                    drain_cnt_d = '0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (acc_mmu_valid_i || drain_cnt_q == CntW'(DrainCycles - 1)) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_q        <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Handshake outputs are forced low while reset is asserted, even with requests pending.
    assign acc_mmu_req_o = rst_ni & mmu_req;
    assign dtlb_hit_o    = {NrPorts{rst_ni}} & hit_vec;
    assign valid_o       = {NrPorts{rst_ni}} & valid_vec;

    assign acc_mmu_vaddr_o         = vaddr_i[sel];
    assign acc_mmu_is_store_o      = is_store_i[sel];
    assign acc_mmu_misaligned_ex_o = misaligned_ex_i[sel];

    assign dtlb_ppn_o  = acc_mmu_dtlb_ppn_i;
    assign paddr_o     = acc_mmu_paddr_i;
    assign exception_o = acc_mmu_exception_i;

endmodule

// File: tb/tb_acc_mmu_arbiter.sv
// Directed bench for acc_mmu_arbiter with two requesters and a 64-cycle drain bound.
module tb_acc_mmu_arbiter;
    import acc_mmu_arbiter_pkg::*;

    logic                     clk_i;
    logic                     rst_ni;
    logic                     flush_i;
    logic [1:0]               req_i;
    logic [1:0][VLEN-1:0]     vaddr_i;
    logic [1:0]               is_store_i;
    exception_t [1:0]         misaligned_ex_i;
    logic [1:0]               dtlb_hit_o;
    logic [PPNW-1:0]          dtlb_ppn_o;
    logic [1:0]               valid_o;
    logic [PLEN-1:0]          paddr_o;
    exception_t               exception_o;
    logic                     acc_mmu_req_o;
    logic [VLEN-1:0]          acc_mmu_vaddr_o;
    logic                     acc_mmu_is_store_o;
    exception_t               acc_mmu_misaligned_ex_o;
    logic                     acc_mmu_dtlb_hit_i;
    logic [PPNW-1:0]          acc_mmu_dtlb_ppn_i;
    logic                     acc_mmu_valid_i;
    logic [PLEN-1:0]          acc_mmu_paddr_i;
    exception_t               acc_mmu_exception_i;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] VA0 = 64'h0000_0000_8000_1000;
    localparam logic [63:0] VA1 = 64'h0000_0000_B000_2000;

    acc_mmu_arbiter #(
        .NrPorts     (2),
        .DrainCycles (64)
    ) dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .flush_i                 (flush_i),
        .req_i                   (req_i),
        .vaddr_i                 (vaddr_i),
        .is_store_i              (is_store_i),
        .misaligned_ex_i         (misaligned_ex_i),
        .dtlb_hit_o              (dtlb_hit_o),
        .dtlb_ppn_o              (dtlb_ppn_o),
        .valid_o                 (valid_o),
        .paddr_o                 (paddr_o),
        .exception_o             (exception_o),
        .acc_mmu_req_o           (acc_mmu_req_o),
        .acc_mmu_vaddr_o         (acc_mmu_vaddr_o),
        .acc_mmu_is_store_o      (acc_mmu_is_store_o),
        .acc_mmu_misaligned_ex_o (acc_mmu_misaligned_ex_o),
        .acc_mmu_dtlb_hit_i      (acc_mmu_dtlb_hit_i),
        .acc_mmu_dtlb_ppn_i      (acc_mmu_dtlb_ppn_i),
        .acc_mmu_valid_i         (acc_mmu_valid_i),
        .acc_mmu_paddr_i         (acc_mmu_paddr_i),
        .acc_mmu_exception_i     (acc_mmu_exception_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [1:0] g;

        rst_ni              = 1'b0;
        flush_i             = 1'b0;
        req_i               = '0;
        vaddr_i             = '0;
        is_store_i          = '0;
        misaligned_ex_i     = '0;
        acc_mmu_dtlb_hit_i  = 1'b0;
        acc_mmu_dtlb_ppn_i  = '0;
        acc_mmu_valid_i     = 1'b0;
        acc_mmu_paddr_i     = '0;
        acc_mmu_exception_i = '0;
        #12;
        chk("reset_req", 64'(acc_mmu_req_o), 64'd0);
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_hit", 64'(dtlb_hit_o), 64'd0);
        chk("reset_vaddr", acc_mmu_vaddr_o, 64'd0);
        chk("reset_paddr", 64'(paddr_o), 64'd0);
        cyc();
        rst_ni = 1'b1;

        // Single requester with DTLB hit
        cyc();
        req_i              = 2'b01;
        vaddr_i[0]         = VA0;
        acc_mmu_dtlb_hit_i = 1'b1;
        acc_mmu_dtlb_ppn_i = 44'h12345;
        #1;
        chk("single_req", 64'(acc_mmu_req_o), 64'd1);
        chk("single_vaddr", acc_mmu_vaddr_o, VA0);
        chk("single_hit", 64'(dtlb_hit_o), 64'b01);
        chk("single_ppn", 64'(dtlb_ppn_o), 64'h12345);
        cyc();
        acc_mmu_dtlb_hit_i = 1'b0;
        acc_mmu_valid_i    = 1'b1;
        acc_mmu_paddr_i    = 56'h9000_1000;
        #1;
        chk("single_valid", 64'(valid_o), 64'b01);
        chk("single_paddr", 64'(paddr_o), 64'h9000_1000);
        cyc();
        req_i           = 2'b00;
        acc_mmu_valid_i = 1'b0;
        #1;
        chk("single_idle_req", 64'(acc_mmu_req_o), 64'd0);
        chk("single_idle_valid", 64'(valid_o), 64'd0);

        // Re-reset so the round-robin pointer starts at port 0
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;

        // Contention: grants alternate 0,1,0,1 every two cycles
        cyc();
        req_i              = 2'b11;
        vaddr_i[1]         = VA1;
        acc_mmu_dtlb_hit_i = 1'b1;
        g = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_vaddr", acc_mmu_vaddr_o, (g == 2'b01) ? VA0 : VA1);
            chk("cont_hit", 64'(dtlb_hit_o), 64'(g));
            cyc();
            acc_mmu_valid_i = 1'b1;
            #1;
            chk("cont_valid", 64'(valid_o), 64'(g));
            cyc();
            acc_mmu_valid_i = 1'b0;
            g = ~g;
        end
        req_i              = 2'b00;
        acc_mmu_dtlb_hit_i = 1'b0;

        // Page walk on port 1 while port 0 waits
        cyc();
        req_i = 2'b10;
        #1;
        chk("walk_grant_vaddr", acc_mmu_vaddr_o, VA1);
        chk("walk_grant_req", 64'(acc_mmu_req_o), 64'd1);
        cyc();
        req_i = 2'b11;
        for (int j = 0; j < 19; j++) begin
            #1;
            chk("walk_hold_vaddr", acc_mmu_vaddr_o, VA1);
            chk("walk_hold_valid", 64'(valid_o), 64'd0);
            cyc();
        end
        acc_mmu_valid_i = 1'b1;
        #1;
        chk("walk_valid", 64'(valid_o), 64'b10);
        cyc();
        acc_mmu_valid_i = 1'b0;
        req_i           = 2'b01;
        #1;
        chk("walk_next_req", 64'(acc_mmu_req_o), 64'd1);
        chk("walk_next_vaddr", acc_mmu_vaddr_o, VA0);
        cyc();
        acc_mmu_valid_i = 1'b1;
        #1;
        chk("walk_next_valid", 64'(valid_o), 64'b01);
        cyc();
        acc_mmu_valid_i = 1'b0;
        req_i           = 2'b00;

        // Flush in BUSY, stale response swallowed in DRAIN
        cyc();
        req_i = 2'b11;
        #1;
        chk("flush_grant_vaddr", acc_mmu_vaddr_o, VA1);
        cyc();
        flush_i = 1'b1;
        #1;
        chk("flush_busy_req", 64'(acc_mmu_req_o), 64'd1);
        chk("flush_busy_valid", 64'(valid_o), 64'd0);
        cyc();
        flush_i = 1'b0;
        for (int d = 0; d < 4; d++) begin
            #1;
            chk("flush_drain_req", 64'(acc_mmu_req_o), 64'd0);
            cyc();
        end
        acc_mmu_valid_i = 1'b1;
        #1;
        chk("flush_stale_valid", 64'(valid_o), 64'd0);
        chk("flush_stale_req", 64'(acc_mmu_req_o), 64'd0);
        cyc();
        acc_mmu_valid_i = 1'b0;
        #1;
        chk("flush_idle_req", 64'(acc_mmu_req_o), 64'd1);
        chk("flush_idle_vaddr", acc_mmu_vaddr_o, VA0);
        cyc();
        acc_mmu_valid_i = 1'b1;
        #1;
        chk("flush_after_valid", 64'(valid_o), 64'b01);
        cyc();
        acc_mmu_valid_i = 1'b0;
        req_i           = 2'b00;

        // Drain timeout after the owner abandons its request
        cyc();
        req_i = 2'b10;
        #1;
        chk("tmo_grant_vaddr", acc_mmu_vaddr_o, VA1);
        cyc();
        req_i = 2'b01;
        #1;
        chk("tmo_abandon_req", 64'(acc_mmu_req_o), 64'd0);
        chk("tmo_abandon_valid", 64'(valid_o), 64'd0);
        for (int d = 0; d < 64; d++) begin
            cyc();
            chk("tmo_drain_req", 64'(acc_mmu_req_o), 64'd0);
        end
        cyc();
        chk("tmo_exit_req", 64'(acc_mmu_req_o), 64'd1);
        chk("tmo_exit_vaddr", acc_mmu_vaddr_o, VA0);
        cyc();
        acc_mmu_valid_i = 1'b1;
        #1;
        chk("tmo_after_valid", 64'(valid_o), 64'b01);
        cyc();
        acc_mmu_valid_i = 1'b0;
        req_i           = 2'b00;

        // valid_i and flush_i together: delivered, no drain
        cyc();
        req_i = 2'b10;
        #1;
        chk("vf_grant_vaddr", acc_mmu_vaddr_o, VA1);
        cyc();
        acc_mmu_valid_i = 1'b1;
        flush_i         = 1'b1;
        #1;
        chk("vf_valid", 64'(valid_o), 64'b10);
        cyc();
        acc_mmu_valid_i = 1'b0;
        flush_i         = 1'b0;
        req_i           = 2'b01;
        #1;
        chk("vf_no_drain_req", 64'(acc_mmu_req_o), 64'd1);
        chk("vf_no_drain_vaddr", acc_mmu_vaddr_o, VA0);

        // Asynchronous reset while BUSY
        cyc();
        acc_mmu_dtlb_hit_i = 1'b1;
        #1;
        chk("rst_busy_hit", 64'(dtlb_hit_o), 64'b01);
        chk("rst_busy_req", 64'(acc_mmu_req_o), 64'd1);
        rst_ni          = 1'b0;
        acc_mmu_valid_i = 1'b1;
        #1;
        chk("rst_async_req", 64'(acc_mmu_req_o), 64'd0);
        chk("rst_async_valid", 64'(valid_o), 64'd0);
        chk("rst_async_hit", 64'(dtlb_hit_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_mmu_arbiter.md
# acc_mmu_arbiter

Shares the single accelerator MMU translation port of the core (the `acc_mmu_*` interface exported under `ARIANE_ACCELERATOR_PORT`) between `NrPorts` accelerator-side requesters, e.g. vector load and store units. It grants one requester at a time in round-robin order and locks the grant until the MMU returns `valid`. It routes the same-cycle DTLB hint and the final translation back to the owner. On a flush or an abandoned request it drains the MMU before re-arbitrating.

## Interface
Parameters:
- `NrPorts`, default 2: number of requesters, must be ≥ 2.
- `DrainCycles`, default 64: maximum wait in DRAIN for a stale `valid_i`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: abort the outstanding translation.
- `req_i` in `[NrPorts]`: translation request. Held high until `valid_o` of that port.
- `vaddr_i` in `[NrPorts][riscv::VLEN]`: virtual address.
- `is_store_i` in `[NrPorts]`: store access.
- `misaligned_ex_i` in `[NrPorts]` `exception_t`: misalignment exception from the requester.
- `dtlb_hit_o` out `[NrPorts]`: DTLB hit, same cycle as the request. Only the granted index is asserted.
- `dtlb_ppn_o` out `riscv::PPNW`: PPN, broadcast to all ports.
- `valid_o` out `[NrPorts]`: translation complete. Only the owner is asserted.
- `paddr_o` out `riscv::PLEN`: translated address, broadcast.
- `exception_o` out `exception_t`: translation exception, broadcast.
- MMU side (`acc_mmu_` prefix, directions reversed to match the core port):
  - `req_o`, `vaddr_o`, `is_store_o`, `misaligned_ex_o`: out.
  - `dtlb_hit_i`, `dtlb_ppn_i`, `valid_i`, `paddr_i`, `exception_i`: in.

## Operation
- The arbiter has three states: IDLE, BUSY and DRAIN.
- Registers:
  - `state_q`
  - `owner_q` (width `$clog2(NrPorts)`)
  - `rr_q` (same width)
  - `drain_cnt_q` (width `$clog2(DrainCycles+1)`)
- **IDLE:**
  - Grant goes to the first asserted `req_i` searching from `rr_q` upward, wrapping modulo `NrPorts`.
  - Grant is combinational: the MMU-side outputs are driven from the granted port in the same cycle.
  - `dtlb_hit_o[grant] = acc_mmu_dtlb_hit_i`.
  - If any request is present: `owner_q <= grant`, next state BUSY.
  - `valid_o` is never asserted in IDLE.
- **BUSY:**
  - The MMU-side outputs are muxed from `owner_q`.
  - `acc_mmu_req_o = req_i[owner_q]`.
  - `dtlb_hit_o[owner_q]` follows `acc_mmu_dtlb_hit_i`.
  - When `acc_mmu_valid_i`:
    - `valid_o[owner_q] = 1`, with `paddr_o` and `exception_o` passed through.
    - `rr_q <= owner_q+1` (wraps to 0).
    - Next state IDLE.
  - `flush_i`, or `req_i[owner_q]` low without `valid_i`:
    - next state DRAIN, `drain_cnt_q <= 0`;
    - `rr_q <= owner_q+1`.
- **Priority:** `valid_i` takes priority over `flush_i` in the same cycle. The translation is delivered, and the flush is then a no-op.
- **DRAIN:**
  - `acc_mmu_req_o = 0`, all `valid_o = 0`, and any `acc_mmu_valid_i` is discarded.
  - Exit to IDLE on `acc_mmu_valid_i` or `drain_cnt_q == DrainCycles-1`.
  - Otherwise `drain_cnt_q` increments.
  - `flush_i` in DRAIN has no further effect.
- **Single outstanding:** at most one translation is outstanding, and losers see no response while waiting.
- **Unselected outputs:**
  - Output data buses are don't-care unless qualified by `valid_o` / `dtlb_hit_o`.
  - MMU-side data is driven from port 0 when no request is present.

## Timing
- **Reset values:**
  - `state_q` = IDLE, `owner_q` = 0, `rr_q` = 0, `drain_cnt_q` = 0.
  - All `valid_o`, `dtlb_hit_o` and `acc_mmu_req_o` are 0.
  - Data outputs are 0 when `req_i` = 0.
- **Added latency:** zero cycles request-to-MMU and zero cycles MMU-response-to-requester.
- **DTLB-hit case:** request at cycle t, `valid_o` at t+1, next grant at t+2. Peak throughput is one translation per 2 cycles.
- **Page-walk case:** `valid_o` arrives whenever `acc_mmu_valid_i` arrives, with the grant held for the whole walk.
- **Drain bound:** a drain lasts 1..`DrainCycles` cycles.
- **Reset mid-operation:** returns to IDLE immediately. The MMU is reset by the same `rst_ni`, so no drain is needed.

## Structure
- `exception_t` comes from `ariane_pkg`; widths `VLEN`, `PLEN` and `PPNW` come from `riscv`.
- The state enum is local to the module; no new package.
- The rotated priority search uses common_cells `lzc` on `req_i` rotated by `rr_q`. No other sub-modules.

## Test plan
- **Single requester:** `req_i` = 01 with `vaddr` 0x8000_1000 and DTLB hit.
  - Expect `acc_mmu_req_o` at t and `dtlb_hit_o` = 01 at t.
  - Expect `valid_o` = 01 with the MMU `paddr` at t+1, then IDLE at t+2.
- **Contention:** `req_i` = 11 held from reset.
  - Expect grants in order 0, 1, 0, 1, every 2 cycles.
  - Expect `valid_o` never to show both bits.
- **Page walk:** port 1 miss with `valid_i` 20 cycles later, and port 0 requesting throughout.
  - Expect port 0 un-granted for the whole walk and granted the cycle after port 1's `valid_o`.
- **Flush in BUSY:**
  - Expect DRAIN with `acc_mmu_req_o` = 0.
  - A stale `valid_i` 5 cycles later is swallowed, with no `valid_o`.
  - IDLE the next cycle, and the grant moves to the other port.
- **Drain timeout:** owner drops `req_i`, and no `valid_i` arrives.
  - Expect exactly 64 DRAIN cycles, then IDLE.
- **Edge cases:**
  - `valid_i` and `flush_i` in the same cycle: expect `valid_o` delivered and no DRAIN.
  - `rst_ni` low during BUSY: expect all outputs 0 asynchronously.
